// File: rtl/shifter_arb_ctrl.sv
// Round-robin arbiter and controller for a WIDTH x DEPTH shift-register delay line,
// with shadow valid/tag tracking and flush. Define AUTO_DRAIN_EN to shift bubbles while idle.
module shifter_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    input  logic [WIDTH-1:0]           req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [WIDTH-1:0]           req1_data,
    output logic                       req1_ready,
    input  logic                       flush,
    output logic                       sh_en,
    output logic [WIDTH-1:0]           sh_si,
    input  logic [WIDTH-1:0]           sh_so,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_src,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       busy
);

    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic             grant;
    logic             grant_valid;
    logic             accept;
    logic             eject;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] tag;
    logic [OW-1:0]    occ_next;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (req0_valid && req1_valid) begin
            grant       = ~last_grant;
            grant_valid = 1'b1;
        end else if (req0_valid) begin
            grant       = 1'b0;
            grant_valid = 1'b1;
        end else if (req1_valid) begin
            grant       = 1'b1;
            grant_valid = 1'b1;
        end
    end

    assign accept     = grant_valid && (state == RUN);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign busy       = (state == FLUSH);

`ifdef AUTO_DRAIN_EN
    assign sh_en = accept || (state == FLUSH) || (occ != '0);
`else
    assign sh_en = accept || (state == FLUSH);
`endif

    assign sh_si    = accept ? (grant ? req1_data : req0_data) : '0;
    assign eject    = sh_en && vld[DEPTH-1];
    assign occ_next = occ + OW'(accept) - OW'(eject);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush && (occ != '0 || accept)) state_next = FLUSH;
            FLUSH:   if (occ_next == '0)                  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // The shadow pipeline is reset so stale shifter contents are never reported;
    // the shifter data itself stays unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state      <= RUN;
            last_grant <= 1'b1;
            vld        <= '0;
            tag        <= '0;
            occ        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
        end else begin
            state <= state_next;
            occ   <= occ_next;
            if (accept) last_grant <= grant;
            if (sh_en) begin
                vld <= {vld[DEPTH-2:0], accept};
                tag <= {tag[DEPTH-2:0], accept & grant};
            end
            out_valid <= eject;
            if (eject) begin
                out_data <= sh_so;
                out_src  <= tag[DEPTH-1];
            end
        end
    end

endmodule

// File: doc/shifter_arb_ctrl.md
Name: shifter_arb_ctrl

Overview:
Controller and arbiter for the WIDTH-bit, DEPTH-stage shift-register delay line, whose ports are clk, shn, si and so; so is the output of the last stage. Two requesters share the delay line through valid/ready handshakes with round-robin arbitration. The block drives shn/si, tracks which stages hold real words with a shadow valid/tag pipeline, and returns ejected words with their source ID. A flush command drains the line with bubbles.

Parameters:
WIDTH, 4, data word width (matches shifter si/so)
DEPTH, 9, number of shifter stages (matches shifter out[0:DEPTH-1])

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_data  in  WIDTH  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle (combinational)
req1_valid  in  1  requester 1 has a word
req1_data  in  WIDTH  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle (combinational)
flush  in  1  request drain of all valid words (sampled on clk)
sh_en  out  1  drives shifter shn; shifter advances on clk when 1
sh_si  out  WIDTH  drives shifter si
sh_so  in  WIDTH  from shifter so (last stage)
out_valid  out  1  one-cycle pulse: ejected word valid
out_data  out  WIDTH  ejected word
out_src  out  1  requester ID of ejected word
occ  out  $clog2(DEPTH+1)  count of valid words in line
busy  out  1  high while in FLUSH

Behaviour:
- Reset (async, rst_n=0): state=RUN, shadow valid bits all 0, tags 0, occ=0, out_valid=0, out_data=0, out_src=0, busy=0, last_grant=1 so req0 wins the first tie. The shifter data has no reset; stale stages are never marked valid.
- States: RUN, FLUSH.
- RUN grant: only req0_valid → grant 0. Only req1_valid → grant 1. Both valid → grant !last_grant. None valid → no grant. Update last_grant on each grant.
- reqX_ready = grant==X && state==RUN. A word is accepted when valid && ready.
- On accept: sh_en=1, sh_si=granted data. Shadow shifts with valid=1, tag=ID inserted at stage 0.
- RUN with no accept: sh_en=0, sh_si=0, shadow holds.
- FLUSH: ready=0 for both, sh_en=1, sh_si=0 every cycle. Shadow shifts with valid=0 inserted.
- Ejection: on any edge where sh_en=1 and shadow valid[DEPTH-1]=1, register out_data<=sh_so, out_src<=tag[DEPTH-1], out_valid<=1. Otherwise out_valid<=0.
- Latency: a word accepted at shift edge n is ejected on the DEPTH-th subsequent shift edge. out_valid is high in the cycle after that edge.
- occ: +1 on accept, -1 on ejection. Accept and eject on the same edge leave occ unchanged. Saturation is impossible: max occ = DEPTH.
- Transitions:
  - RUN→FLUSH when flush=1 and (occ>0 or an accept occurs this cycle). An accept in the same cycle completes first.
  - flush=1 with occ=0 and no accept: ignored.
  - FLUSH→RUN on the edge where occ becomes 0. flush is ignored during FLUSH.
- busy = (state==FLUSH).
- rst_n asserted mid-flush or mid-stream: immediate return to reset values. Words in flight are discarded and never reported.

Optional Feature:
AUTO_DRAIN_EN. When defined, in RUN with no accept and occ>0, the block still shifts a bubble (sh_en=1, sh_si=0, valid=0 inserted). Every word then ejects exactly DEPTH edges after acceptance, whether or not traffic follows. When undefined, the line advances only on accepts or in FLUSH. Words may wait indefinitely until later traffic or a flush pushes them out.

Test Plan:
1. Reset; req0 sends 4'h6 once, then req1 sends 9 words 4'h1 → out_valid=1, out_data=4'h6, out_src=0 in the cycle after the 10th accept edge; occ=9 thereafter.
2. req0 and req1 both valid continuously from reset → grants alternate 0,1,0,1… starting with 0. Once ejections start, out_src alternates 0,1,… and occ holds at 9.
3. Accept 4'hB, 4'h1, 4'hF, then pulse flush → busy=1 for exactly 9 cycles with both readys 0 and sh_en=1. Outputs B, 1, F are reported with out_valid in the cycles after flush shifts 7, 8, 9; then busy=0 and occ=0.
4. flush pulse with occ=0 and no requests → busy stays 0, sh_en stays 0, no out_valid.
5. Accept 4'hF, start a flush, assert rst_n=0 mid-flush, release → all outputs 0 immediately, no stale out_valid. A new accept of 4'h6 is later ejected normally.
6. AUTO_DRAIN_EN defined: single req0 word 4'h6 then idle → out_valid with 4'h6 exactly 9 edges after acceptance, occ returns to 0. Undefined: no out_valid, occ stays 1.
